// File: rtl/distribute_1x2_dst_tag_pipe_if.sv
// Handshake and payload bundle for the 1x2 destination-tag distributor.
// The slave modport is the distributor's view; the master modport belongs to whoever drives it.
interface distribute_1x2_dst_tag_pipe_if #(
    parameter int DATA_WIDTH       = 32,
    parameter int IN_COMMAND_WIDTH = 4
);
    localparam int OCW = (IN_COMMAND_WIDTH > 2) ? IN_COMMAND_WIDTH - 2 : 1;

    logic                      i_en;
    logic                      i_valid;
    logic                      i_ready;
    logic [DATA_WIDTH-1:0]     i_data_bus;
    logic [IN_COMMAND_WIDTH-1:0] i_cmd;
    logic [1:0]                o_valid;
    logic [1:0]                o_ready;
    logic [2*DATA_WIDTH-1:0]   o_data_bus;
    logic [2*OCW-1:0]          o_cmd;
    logic                      o_drop;

    modport slave (
        input  i_en, i_valid, i_data_bus, i_cmd, o_ready,
        output i_ready, o_valid, o_data_bus, o_cmd, o_drop
    );

    modport master (
        output i_en, i_valid, i_data_bus, i_cmd, o_ready,
        input  i_ready, o_valid, o_data_bus, o_cmd, o_drop
    );
endinterface

// File: rtl/distribute_1x2_dst_tag_pipe.sv
// Routes input beats to a high and/or low branch FIFO using the top two tag bits.
// Each branch buffers {data, remaining tag}; a full branch stalls the whole input.
module distribute_1x2_dst_tag_pipe_branch #(
    parameter int DW    = 32,
    parameter int CW    = 2,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic [CW-1:0] cmd_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic          full_o,
    output logic [DW-1:0] data_o,
    output logic [CW-1:0] cmd_o
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] cmd;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0] cnt_q;
    logic            push_ok, pop;

    assign full_o  = (cnt_q == CNTW'(DEPTH));
    assign valid_o = (cnt_q != '0);
    assign push_ok = push_i && !full_o;
    assign pop     = ready_i && valid_o;
    assign data_o  = valid_o ? mem_q[rd_ptr_q].data : '0;
    assign cmd_o   = valid_o ? mem_q[rd_ptr_q].cmd  : '0;

    // Pointers are exactly AW bits wide, so wrap comes free from the power-of-2 depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push_ok, pop})
                2'b10:   cnt_q <= cnt_q + CNTW'(1);
                2'b01:   cnt_q <= cnt_q - CNTW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= '{data: data_i, cmd: cmd_i};
    end
endmodule

module distribute_1x2_dst_tag_pipe #(
    parameter int DATA_WIDTH       = 32,
    parameter int IN_COMMAND_WIDTH = 4,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic clk,
    input  logic rst_n,
    distribute_1x2_dst_tag_pipe_if.slave bus
);
    localparam int OUT_COMMAND_WIDTH_PER_DATA = (IN_COMMAND_WIDTH > 2) ? IN_COMMAND_WIDTH - 2 : 1;
    localparam int OCW = OUT_COMMAND_WIDTH_PER_DATA;

    logic [1:0]                 tag;
    logic [OCW-1:0]             rem_cmd;
    logic                       accept;
    logic [1:0]                 push, full;
    logic [1:0][DATA_WIDTH-1:0] br_data;
    logic [1:0][OCW-1:0]        br_cmd;
    logic                       drop_q;

    assign tag = bus.i_cmd[IN_COMMAND_WIDTH-1 -: 2];

    generate
        if (IN_COMMAND_WIDTH > 2) begin : g_fwd_cmd
            assign rem_cmd = bus.i_cmd[OCW-1:0];
        end else begin : g_last_stage
            assign rem_cmd = '0;
        end
    endgenerate

    // Gating with rst_n keeps i_ready low for the whole time reset is asserted.
    assign bus.i_ready = rst_n && bus.i_en && !full[1] && !full[0];
    assign accept      = bus.i_valid && bus.i_ready;
    assign push        = {accept && tag[1], accept && tag[0]};

    generate
        for (genvar b = 0; b < 2; b++) begin : g_br
            distribute_1x2_dst_tag_pipe_branch #(
                .DW(DATA_WIDTH), .CW(OCW), .DEPTH(FIFO_DEPTH)
            ) u_fifo (
                .clk     (clk),
                .rst_n   (rst_n),
                .push_i  (push[b]),
                .data_i  (bus.i_data_bus),
                .cmd_i   (rem_cmd),
                .ready_i (bus.o_ready[b]),
                .valid_o (bus.o_valid[b]),
                .full_o  (full[b]),
                .data_o  (br_data[b]),
                .cmd_o   (br_cmd[b])
            );
        end
    endgenerate

    assign bus.o_data_bus = br_data;
    assign bus.o_cmd      = br_cmd;
    assign bus.o_drop     = drop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_q <= 1'b0;
        else        drop_q <= accept && (tag == 2'b00);
    end
endmodule

// File: tb/tb_distribute_1x2_dst_tag_pipe.sv
// Self-checking bench: per-branch queue model compared every cycle plus directed literal checks.
module tb_distribute_1x2_dst_tag_pipe;
    localparam int DW = 32;
    localparam int ICW = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    distribute_1x2_dst_tag_pipe_if #(.DATA_WIDTH(DW), .IN_COMMAND_WIDTH(ICW)) intf ();

    distribute_1x2_dst_tag_pipe #(
        .DATA_WIDTH(DW), .IN_COMMAND_WIDTH(ICW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (intf.slave)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic [1:0]    c;
    } ent_t;

    ent_t qh[$];
    ent_t ql[$];
    logic drop_exp = 1'b0;
    bit   m_acc, m_ph, m_pl;
    logic [1:0] m_tag;
    ent_t m_e;

    // Model: a beat is taken when enabled and neither queue holds DEPTH entries.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qh.delete();
            ql.delete();
            drop_exp = 1'b0;
        end else begin
            m_acc = intf.i_valid && intf.i_en && qh.size() < DEPTH && ql.size() < DEPTH;
            m_ph  = intf.o_ready[1] && qh.size() > 0;
            m_pl  = intf.o_ready[0] && ql.size() > 0;
            if (m_ph) void'(qh.pop_front());
            if (m_pl) void'(ql.pop_front());
            m_tag = intf.i_cmd[3:2];
            m_e.d = intf.i_data_bus;
            m_e.c = intf.i_cmd[1:0];
            if (m_acc && m_tag[1]) qh.push_back(m_e);
            if (m_acc && m_tag[0]) ql.push_back(m_e);
            drop_exp = m_acc && (m_tag == 2'b00);
        end
    end

    logic [1:0]    e_valid;
    logic [63:0]   e_data;
    logic [3:0]    e_cmd;
    logic          e_ready;

    always @(negedge clk) begin
        e_valid = {qh.size() != 0, ql.size() != 0};
        e_data  = {(qh.size() != 0) ? qh[0].d : 32'h0, (ql.size() != 0) ? ql[0].d : 32'h0};
        e_cmd   = {(qh.size() != 0) ? qh[0].c : 2'b00, (ql.size() != 0) ? ql[0].c : 2'b00};
        e_ready = rst_n && intf.i_en && qh.size() < DEPTH && ql.size() < DEPTH;
        checks++;
        if (intf.o_valid !== e_valid || intf.o_data_bus !== e_data || intf.o_cmd !== e_cmd ||
            intf.i_ready !== e_ready || intf.o_drop !== drop_exp) begin
            errors++;
            $display("FAIL model t=%0t: got v=%b d=%h c=%b rdy=%b drop=%b, want v=%b d=%h c=%b rdy=%b drop=%b",
                     $time, intf.o_valid, intf.o_data_bus, intf.o_cmd, intf.i_ready, intf.o_drop,
                     e_valid, e_data, e_cmd, e_ready, drop_exp);
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] c);
        intf.i_valid    = v;
        intf.i_data_bus = d;
        intf.i_cmd      = c;
    endtask

    int acc_cnt;
    int iter;

    initial begin
        intf.i_en = 1'b1;
        intf.o_ready = 2'b11;
        drive(1'b0, 32'h0, 4'h0);
        #1;
        chk("reset_valid", 64'(intf.o_valid), 64'h0);
        chk("reset_ready", 64'(intf.i_ready), 64'h0);
        chk("reset_data",  intf.o_data_bus, 64'h0);
        chk("reset_drop",  64'(intf.o_drop), 64'h0);
        step();
        rst_n = 1'b1;
        #1;
        chk("ready_after_release", 64'(intf.i_ready), 64'h1);

        // Unicast to high branch
        drive(1'b1, 32'hA5A5_0001, 4'b1011);
        step();
        drive(1'b0, 32'h0, 4'h0);
        chk("uni_valid", 64'(intf.o_valid), 64'h2);
        chk("uni_data",  intf.o_data_bus, 64'hA5A5_0001_0000_0000);
        chk("uni_cmd",   64'(intf.o_cmd), 64'hC);
        step();
        chk("uni_popped", 64'(intf.o_valid), 64'h0);

        // Multicast
        intf.o_ready = 2'b00;
        drive(1'b1, 32'h1234, 4'b1101);
        step();
        drive(1'b0, 32'h0, 4'h0);
        chk("mc_valid", 64'(intf.o_valid), 64'h3);
        chk("mc_data",  intf.o_data_bus, 64'h0000_1234_0000_1234);
        chk("mc_cmd",   64'(intf.o_cmd), 64'h5);
        intf.o_ready = 2'b11;
        step();
        chk("mc_one_pop", 64'(intf.o_valid), 64'h0);

        // Backpressure: fill low branch, high-bound beat must also stall
        intf.o_ready = 2'b00;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 32'(i), 4'b0100);
            step();
        end
        chk("bp_full_ready", 64'(intf.i_ready), 64'h0);
        drive(1'b1, 32'h99, 4'b1000);
        step();
        chk("bp_hol_valid", 64'(intf.o_valid), 64'h1);
        chk("bp_hol_ready", 64'(intf.i_ready), 64'h0);
        intf.o_ready = 2'b01;
        step();
        intf.o_ready = 2'b00;
        chk("bp_ready_back", 64'(intf.i_ready), 64'h1);
        chk("bp_head2", 64'(intf.o_data_bus[31:0]), 64'h2);
        step();
        drive(1'b0, 32'h0, 4'h0);
        chk("bp_high_taken", 64'(intf.o_valid), 64'h3);
        intf.o_ready = 2'b01;
        step();
        chk("bp_head3", 64'(intf.o_data_bus[31:0]), 64'h3);
        step();
        chk("bp_head4", 64'(intf.o_data_bus[31:0]), 64'h4);
        intf.o_ready = 2'b11;
        step();
        step();
        chk("bp_drained", 64'(intf.o_valid), 64'h0);

        // Drop
        drive(1'b1, 32'hDEAD, 4'b0011);
        step();
        drive(1'b0, 32'h0, 4'h0);
        chk("drop_pulse", 64'(intf.o_drop), 64'h1);
        chk("drop_valid", 64'(intf.o_valid), 64'h0);
        step();
        chk("drop_one_cycle", 64'(intf.o_drop), 64'h0);

        // Push and pop in the same cycle at count DEPTH-1
        intf.o_ready = 2'b00;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h50 + 32'(i), 4'b0110);
            step();
        end
        intf.o_ready = 2'b01;
        drive(1'b1, 32'h53, 4'b0110);
        step();
        drive(1'b0, 32'h0, 4'h0);
        intf.o_ready = 2'b00;
        chk("pp_ready", 64'(intf.i_ready), 64'h1);
        chk("pp_head",  64'(intf.o_data_bus[31:0]), 64'h51);
        intf.o_ready = 2'b11;
        for (int i = 0; i < 4; i++) step();

        // Enable low: no accept, stored entries still drain
        intf.o_ready = 2'b00;
        drive(1'b1, 32'h77, 4'b1000);
        step();
        intf.i_en = 1'b0;
        drive(1'b1, 32'h78, 4'b1000);
        #1;
        chk("en_low_ready", 64'(intf.i_ready), 64'h0);
        intf.o_ready = 2'b11;
        step();
        step();
        chk("en_low_drain", 64'(intf.o_valid), 64'h0);
        intf.i_en = 1'b1;
        drive(1'b0, 32'h0, 4'h0);

        // Random beats with random downstream ready
        acc_cnt = 0;
        iter = 0;
        while (acc_cnt < 20 && iter < 400) begin
            intf.o_ready = 2'($urandom_range(0, 3));
            intf.i_en = ($urandom_range(0, 7) != 0);
            drive(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
            #1;
            if (intf.i_valid && intf.i_ready) acc_cnt++;
            step();
            iter++;
        end
        chk("rand_budget", 64'(acc_cnt >= 20), 64'h1);
        drive(1'b0, 32'h0, 4'h0);
        intf.i_en = 1'b1;
        intf.o_ready = 2'b11;
        for (int i = 0; i < 6; i++) step();
        chk("rand_drained", 64'(intf.o_valid), 64'h0);

        // Reset with three entries buffered
        intf.o_ready = 2'b00;
        drive(1'b1, 32'hA1, 4'b1000); step();
        drive(1'b1, 32'hA2, 4'b0100); step();
        drive(1'b1, 32'hA3, 4'b1100); step();
        drive(1'b0, 32'h0, 4'h0);
        chk("pre_rst_valid", 64'(intf.o_valid), 64'h3);
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(intf.o_valid), 64'h0);
        chk("rst_data",  intf.o_data_bus, 64'h0);
        chk("rst_cmd",   64'(intf.o_cmd), 64'h0);
        chk("rst_ready", 64'(intf.i_ready), 64'h0);
        step();
        rst_n = 1'b1;
        intf.o_ready = 2'b11;
        step();
        chk("post_rst_valid", 64'(intf.o_valid), 64'h0);
        chk("post_rst_ready", 64'(intf.i_ready), 64'h1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/distribute_1x2_dst_tag_pipe.md
DISTRIBUTE_1X2_DST_TAG_PIPE -- requirements
Module: distribute_1x2_dst_tag_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, payload width per port.
REQ-002 SHALL have parameter IN_COMMAND_WIDTH, default 4, input destination tag width, >=2; the top 2 bits are consumed by this stage.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, entries per output branch, power of 2, >=2.
REQ-004 SHALL derive OUT_COMMAND_WIDTH_PER_DATA = IN_COMMAND_WIDTH-2 when IN_COMMAND_WIDTH>2, else 1 (LAST_STAGE, o_cmd tied 0).
REQ-005 SHALL use one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 i_en  input  1  switch enable.
REQ-008 i_valid  input  1  input beat valid.
REQ-009 i_ready  output  1  input beat accepted when i_valid&i_ready.
REQ-010 i_data_bus  input  DATA_WIDTH  input payload.
REQ-011 i_cmd  input  IN_COMMAND_WIDTH  tag; [MSB]=high branch, [MSB-1]=low branch, 2'b11 multicast, 2'b00 drop.
REQ-012 o_valid  output  2  per-branch valid, bit1=high, bit0=low.
REQ-013 o_ready  input  2  per-branch downstream ready.
REQ-014 o_data_bus  output  2*DATA_WIDTH  {o_data_high, o_data_low}.
REQ-015 o_cmd  output  2*OUT_COMMAND_WIDTH_PER_DATA  {cmd_high, cmd_low}, remaining tag bits i_cmd[OUT_COMMAND_WIDTH_PER_DATA-1:0].
REQ-016 o_drop  output  1  one-cycle pulse when a 2'b00-tagged beat is accepted and discarded.

Function
REQ-017 Each branch SHALL own a FIFO of FIFO_DEPTH entries of {data, remaining cmd} with read/write pointers and a count of width clog2(FIFO_DEPTH)+1.
REQ-018 i_ready SHALL equal i_en && count_high<FIFO_DEPTH && count_low<FIFO_DEPTH, independent of i_cmd and i_valid.
REQ-019 On accept with tag 2'b10 SHALL push high FIFO only; 2'b01 low FIFO only; 2'b11 both FIFOs in the same cycle (atomic multicast); 2'b00 neither, o_drop=1 next cycle.
REQ-020 Push SHALL be registered: a beat accepted in cycle N appears on o_valid in cycle N+1 at earliest; no combinational input-to-output path.
REQ-021 o_valid[b] SHALL equal count_b!=0; o_data/o_cmd of branch b SHALL show the FIFO head when valid, all zeros otherwise.
REQ-022 Branch b SHALL pop when o_valid[b]&&o_ready[b]; branches pop independently, preserving per-branch FIFO order.
REQ-023 Simultaneous push and pop on a branch SHALL leave count unchanged and advance both pointers.
REQ-024 Pointers SHALL wrap modulo FIFO_DEPTH; count SHALL never exceed FIFO_DEPTH nor underflow.
REQ-025 When i_en=0: i_ready=0, no pushes; stored entries SHALL continue to drain.
REQ-026 In LAST_STAGE, pushed cmd SHALL be 0 and o_cmd SHALL be all zeros.
REQ-027 No data-dependent stall: a full branch SHALL block all input (head-of-line), including beats for the other branch.

Reset
REQ-028 On rst_n=0, immediately and asynchronously: counts and pointers 0, o_valid=2'b00, o_data_bus=0, o_cmd=0, o_drop=0, i_ready=0.
REQ-029 Reset mid-transfer SHALL discard all buffered entries; no partial multicast SHALL survive.
REQ-030 After rst_n deassertion, i_ready SHALL follow REQ-018 in the first clock cycle.

Verification
REQ-031 Unicast: DATA_WIDTH=32, i_cmd=4'b10_11, data 0xA5A5_0001, o_ready=2'b11 -> cycle+1 o_valid=2'b10, o_data_high=0xA5A5_0001, cmd_high=2'b11, low side zero.
REQ-032 Multicast: i_cmd=4'b11_01, data 0x1234 -> cycle+1 o_valid=2'b11, both data 0x1234, both cmd 2'b01; one pop each.
REQ-033 Backpressure: o_ready=2'b00, 4 beats to low (FIFO_DEPTH=4) -> i_ready=0 after 4th accept, high-bound beat also blocked; o_ready[0]=1 one cycle -> i_ready=1 next cycle, order 1,2,3,4 preserved.
REQ-034 Drop: i_cmd=4'b00_xx accepted -> o_drop=1 one cycle, o_valid stays 2'b00, counts 0.
REQ-035 Wrap/concurrency: 20 random beats with random o_ready, push/pop same cycle when count=FIFO_DEPTH-1 -> per-branch scoreboard match, no loss or duplication.
REQ-036 Reset mid-operation: rst_n low with 3 entries buffered -> outputs zero same cycle; after release o_valid=2'b00 until new accept.
